booth_mul_seq: RTL and testbench

- Parametrised sequential Booth multiplier; successor to the fixed 64-bit radix-2 datapath.
- Adds parametric WIDTH, a signed/unsigned mode and a start/busy/done handshake with abort.
- Adds a held result register, plus an optional radix-4 recoding mode.
- Sits between the top-level FSM/controller and the result bus; one operation in flight at a time.

---
 rtl/booth_mul_pkg.sv | 32 +++
 rtl/booth_mul_seq_recoder.sv | 50 +++++
 rtl/booth_mul_seq.sv | 121 ++++++++++++
 tb/tb_booth_mul_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// Build option: define BOOTH_MUL_RADIX4_EN to select radix-4 recoding (radix-2 otherwise).
package booth_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ADD1 = 3'd1,
        SUB1 = 3'd2,
        ADD2 = 3'd3,
        SUB2 = 3'd4
    } recode_op_t;

`ifdef BOOTH_MUL_RADIX4_EN
    localparam bit RADIX4 = 1'b1;
`else
    localparam bit RADIX4 = 1'b0;
`endif

    // Radix-4 looks at {X[1],X[0],x_prev}; radix-2 at {X[0],x_prev}.
    localparam int RECODE_BITS = RADIX4 ? 3 : 2;

    function automatic int booth_num_iter(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 2;
    endfunction

endpackage

// File: rtl/booth_mul_seq_recoder.sv
// Combinational Booth digit recoder: turns the recode window into a signed E+1 bit addend.
// Build option: BOOTH_MUL_RADIX4_EN selects the radix-4 digit set {0,+-M,+-2M}.
module booth_recoder
    import booth_mul_pkg::*;
#(
    parameter int E = 10
) (
    input  logic [RECODE_BITS-1:0] bits,
    input  logic [E-1:0]           m,
    output logic [E:0]             addend
);

    recode_op_t op;
    logic [E:0] m1;
    logic [E:0] m2;

    assign m1 = {m[E-1], m};
    assign m2 = {m, 1'b0};

    always_comb begin
        op = NOP;
`ifdef BOOTH_MUL_RADIX4_EN
        case (bits)
            3'b001, 3'b010: op = ADD1;
            3'b011:         op = ADD2;
            3'b100:         op = SUB2;
            3'b101, 3'b110: op = SUB1;
            default:        op = NOP;
        endcase
`else
        case (bits)
            2'b01:   op = ADD1;
            2'b10:   op = SUB1;
            default: op = NOP;
        endcase
`endif
    end

    always_comb begin
        addend = '0;
        case (op)
            ADD1:    addend = m1;
            SUB1:    addend = -m1;
            ADD2:    addend = m2;
            SUB2:    addend = -m2;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier with start/busy/done handshake, abort and held result.
// Build option: BOOTH_MUL_RADIX4_EN enables radix-4 recoding (halves the iteration count).
module booth_mul_seq
    import booth_mul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int E  = WIDTH + 2;
    localparam int UW = RADIX4 ? E + 1 : E;
    localparam int N  = booth_num_iter(WIDTH, RADIX4);
    localparam int CW = $clog2(E) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                 state;
    logic [UW-1:0]          u;
    logic [E-1:0]           x;
    logic [E-1:0]           m;
    logic                   x_prev;
    logic [CW-1:0]          cnt;

    logic [E-1:0]           a_ext;
    logic [E-1:0]           b_ext;
    logic [RECODE_BITS-1:0] rbits;
    logic [E:0]             addend;
    logic [E:0]             u_w;
    logic [E:0]             sum;
    logic [UW-1:0]          u_nxt;
    logic [E-1:0]           x_nxt;
    logic                   xp_nxt;

    assign a_ext = op_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    assign b_ext = op_signed ? {{2{multiplier[WIDTH-1]}}, multiplier}     : {2'b00, multiplier};

`ifdef BOOTH_MUL_RADIX4_EN
    assign rbits  = {x[1:0], x_prev};
    assign u_w    = u;
    assign sum    = u_w + addend;
    assign u_nxt  = {{2{sum[E]}}, sum[E:2]};
    assign x_nxt  = {sum[1:0], x[E-1:2]};
    assign xp_nxt = x[1];
`else
    // Add in E+1 bits so the true sign of the sum feeds the arithmetic shift.
    assign rbits  = {x[0], x_prev};
    assign u_w    = {u[E-1], u};
    assign sum    = u_w + addend;
    assign u_nxt  = {sum[E], sum[E-1:1]};
    assign x_nxt  = {sum[0], x[E-1:1]};
    assign xp_nxt = x[0];
`endif

    booth_recoder #(.E(E)) u_recoder (
        .bits   (rbits),
        .m      (m),
        .addend (addend)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            u      <= '0;
            x      <= '0;
            m      <= '0;
            x_prev <= 1'b0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (op_clear) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (op_start) begin
                        u      <= '0;
                        x      <= b_ext;
                        m      <= a_ext;
                        x_prev <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    u      <= u_nxt;
                    x      <= x_nxt;
                    x_prev <= xp_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Product lives in {U,X}; only the low 2*WIDTH bits are meaningful.
                    result <= {u[WIDTH-3:0], x};
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and randomised checks of booth_mul_seq at WIDTH 8, 16 and 64.
module tb_booth_mul_seq;

`ifdef BOOTH_MUL_RADIX4_EN
    localparam bit R4 = 1'b1;
`else
    localparam bit R4 = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         op_clear;
    logic         op_signed;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [2:0]   start;
    logic [2:0]   busy;
    logic [2:0]   done;
    logic [15:0]  r8;
    logic [31:0]  r16;
    logic [127:0] r64;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .op_start(start[0]), .op_clear(op_clear), .op_signed(op_signed),
        .multiplicand(a[7:0]), .multiplier(b[7:0]), .result(r8), .busy(busy[0]), .done(done[0])
    );
    booth_mul_seq #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .op_start(start[1]), .op_clear(op_clear), .op_signed(op_signed),
        .multiplicand(a[15:0]), .multiplier(b[15:0]), .result(r16), .busy(busy[1]), .done(done[1])
    );
    booth_mul_seq #(.WIDTH(64)) u64 (
        .clk(clk), .reset(reset), .op_start(start[2]), .op_clear(op_clear), .op_signed(op_signed),
        .multiplicand(a), .multiplier(b), .result(r64), .busy(busy[2]), .done(done[2])
    );

    typedef struct {
        string        name;
        int           sel;
        bit           sgn;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic int width_of(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 16 : 64;
    endfunction

    function automatic int exp_lat(input int w);
        return (R4 ? w / 2 + 1 : w + 2) + 1;
    endfunction

    function automatic logic [127:0] get_res(input int sel);
        case (sel)
            0:       return {112'd0, r8};
            1:       return {96'd0, r16};
            default: return r64;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for done", name);
    endtask

    // Start an op, then count edges until done appears; check busy and the single-cycle done.
    task automatic run_op(input string name, input int sel, input bit sgn,
                          input logic [63:0] aa, input logic [63:0] bb,
                          output logic [127:0] res, output int lat);
        @(negedge clk);
        a = aa; b = bb; op_signed = sgn; start[sel] = 1'b1;
        @(posedge clk); #1;
        start[sel] = 1'b0;
        check({name, "_busy"}, {127'd0, busy[sel]}, 128'd1);
        lat = 0;
        while (!done[sel] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = get_res(sel);
        if (lat >= 300) fail_timeout(name);
        else begin
            check({name, "_lat"}, 128'(lat), 128'(exp_lat(width_of(sel))));
            check({name, "_busy_done"}, {127'd0, busy[sel]}, 128'd0);
            @(posedge clk); #1;
            check({name, "_pulse"}, {127'd0, done[sel]}, 128'd0);
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done[0]) seen++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        int           lat;
        int           seen;
        logic [15:0]  ra, rb;
        logic [31:0]  rexp;
        bit           rs;

        vecs[0] = '{"s8_m3x5",    0, 1'b1, 64'hFD, 64'h05, 128'hFFF1};
        vecs[1] = '{"u8_ffxff",   0, 1'b0, 64'hFF, 64'hFF, 128'hFE01};
        vecs[2] = '{"s8_ffxff",   0, 1'b1, 64'hFF, 64'hFF, 128'h0001};
        vecs[3] = '{"s8_80x80",   0, 1'b1, 64'h80, 64'h80, 128'h4000};
        vecs[4] = '{"s8_7fx80",   0, 1'b1, 64'h7F, 64'h80, 128'hC080};
        vecs[5] = '{"s64_m1x2",   2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
                    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{"u64_maxx2",  2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
                    128'h0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE};
        vecs[7] = '{"s16_minmin", 1, 1'b1, 64'h8000, 64'h8000, 128'h4000_0000};
        vecs[8] = '{"u16_maxmax", 1, 1'b0, 64'hFFFF, 64'hFFFF, 128'hFFFE_0001};
        vecs[9] = '{"u8_7x6",     0, 1'b0, 64'h07, 64'h06, 128'd42};

        reset = 1'b1; op_clear = 1'b0; op_signed = 1'b0; a = '0; b = '0; start = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result8",  {112'd0, r8}, 128'd0);
        check("rst_result64", r64, 128'd0);
        check("rst_busy",     {125'd0, busy}, 128'd0);
        check("rst_done",     {125'd0, done}, 128'd0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].sel, vecs[i].sgn, vecs[i].a, vecs[i].b, res, lat);
            check(vecs[i].name, res, vecs[i].exp);
        end

        // Abort in the 4th EXEC cycle; previous result (42) must be wiped.
        @(negedge clk);
        a = 64'd7; b = 64'd6; op_signed = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", {127'd0, busy[0]}, 128'd1);
        @(negedge clk) op_clear = 1'b1;
        @(posedge clk); #1;
        op_clear = 1'b0;
        check("abort_busy",   {127'd0, busy[0]}, 128'd0);
        check("abort_result", {112'd0, r8}, 128'd0);
        check("abort_done",   {127'd0, done[0]}, 128'd0);
        count_done(15, seen);
        check("abort_no_done", 128'(seen), 128'd0);
        run_op("abort_restart", 0, 1'b0, 64'd7, 64'd6, res, lat);
        check("abort_restart", res, 128'd42);

        // Same with reset in place of op_clear.
        @(negedge clk);
        a = 64'd7; b = 64'd6; op_signed = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstop_busy",   {127'd0, busy[0]}, 128'd0);
        check("rstop_result", {112'd0, r8}, 128'd0);
        count_done(15, seen);
        check("rstop_no_done", 128'(seen), 128'd0);
        run_op("rstop_restart", 0, 1'b0, 64'd7, 64'd6, res, lat);
        check("rstop_restart", res, 128'd42);

        // op_start held high, operands changed mid-operation.
        @(negedge clk);
        a = 64'hFD; b = 64'h05; op_signed = 1'b1; start[0] = 1'b1;
        @(posedge clk); #1;
        a = 64'd9; b = 64'd10; op_signed = 1'b0;
        lat = 0;
        while (!done[0] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 300) fail_timeout("hold_first");
        check("hold_lat",    128'(lat), 128'(exp_lat(8)));
        check("hold_result", {112'd0, r8}, 128'hFFF1);
        check("hold_busy_in_done", {127'd0, busy[0]}, 128'd0);
        @(posedge clk); #1;
        check("hold_restart_busy", {127'd0, busy[0]}, 128'd1);
        start[0] = 1'b0;
        lat = 0;
        while (!done[0] && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 300) fail_timeout("hold_second");
        check("hold_second", {112'd0, r8}, 128'd90);

        // Start and clear together in IDLE: clear wins.
        @(negedge clk);
        start[0] = 1'b1; op_clear = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; op_clear = 1'b0;
        check("startclr_busy",   {127'd0, busy[0]}, 128'd0);
        check("startclr_result", {112'd0, r8}, 128'd0);
        count_done(15, seen);
        check("startclr_no_done", 128'(seen), 128'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (rs) rexp = 32'($signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb}));
            else    rexp = {16'd0, ra} * {16'd0, rb};
            run_op("rand16", 1, rs, {48'd0, ra}, {48'd0, rb}, res, lat);
            check("rand16", res, {96'd0, rexp});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
